// File: rtl/cv32e40x_pkg.sv
// Shared LSU types: WB response-tracker states and the load/store size encoding.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT0 = 2'b01,
    WAIT1 = 2'b10,
    DONE  = 2'b11
  } lsu_wb_resp_state_e;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  // Number of bus responses still owed by a WB load/store in state st.
  function automatic logic [1:0] lsu_beats_owed(input lsu_wb_resp_state_e st,
                                                input logic               split);
    logic [1:0] owed;
    unique case (st)
      WAIT0:   owed = split ? 2'd2 : 2'd1;
      WAIT1:   owed = 2'd1;
      default: owed = 2'd0;
    endcase
    return owed;
  endfunction

endpackage

// File: rtl/cv32e40x_lsu_rdata_align.sv
// Combinational load-data aligner: picks the addressed byte/half/word out of one
// or two response beats and zero- or sign-extends it to 32 bits.
module cv32e40x_lsu_rdata_align
  import cv32e40x_pkg::*;
(
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  input  logic        split_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  addr_lsb_i,
  output logic [31:0] rdata_o
);

  logic [63:0] word64;
  logic [31:0] shifted;

  // Concatenate both beats, shift the addressed byte down to bit 0, then extend.
  always_comb begin
    word64  = {(split_i ? rdata1_i : 32'h0000_0000), rdata0_i};
    shifted = 32'(word64 >> {addr_lsb_i, 3'b000});
    unique case (size_i)
      BYTE:    rdata_o = {{24{sext_i & shifted[7]}},  shifted[7:0]};
      HALF:    rdata_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/cv32e40x_lsu_wb_resp.sv
// WB-stage load/store response collector: counts OBI response beats for the
// instruction in WB, merges split loads, aligns data, flags errors, and drops
// responses that still arrive for killed instructions.
module cv32e40x_lsu_wb_resp
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_wb_i,
  input  logic        split_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic        kill_wb_i,
  input  logic        halt_wb_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_ready_wb_o,
  output logic        lsu_err_o,
  output logic        busy_o
);

  localparam int unsigned     DW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DW-1:0]   MAX_CNT = DW'(MAX_OUTSTANDING);

  lsu_wb_resp_state_e state_q;
  lsu_wb_resp_state_e st;
  logic [1:0]         beat_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        rdata0_q;
  logic [31:0]        rdata1_q;
  logic [DW-1:0]      drop_cnt_q;
  logic [DW-1:0]      drop_cnt_d;

  logic               drop_hit;
  logic               resp_wb;
  logic               final_beat;
  logic               ready;
  logic               retire;
  logic               err_cur;
  logic [1:0]         owed_raw;
  logic [1:0]         owed_kill;
  logic [31:0]        al_rdata0;
  logic [31:0]        al_rdata1;
  logic [31:0]        aligned;

  // An instruction newly arrived in WB owes its first beat in its very first cycle,
  // so IDLE with a request is treated as WAIT0 without waiting for the register.
  always_comb begin
    st = state_q;
    if (state_q == IDLE && data_req_wb_i) begin
      st = WAIT0;
    end
  end

  // Route responses (drops first), detect the final beat, and compute kill bookkeeping.
  always_comb begin
    drop_hit   = resp_valid_i && (drop_cnt_q != '0);
    resp_wb    = resp_valid_i && (drop_cnt_q == '0) && data_req_wb_i;
    final_beat = resp_wb && ((st == WAIT0 && !split_i) || st == WAIT1);
    ready      = !data_req_wb_i || final_beat || done_q;
    retire     = data_req_wb_i && ready && !halt_wb_i && !kill_wb_i;
    owed_raw   = lsu_beats_owed(st, split_i);
    owed_kill  = owed_raw - 2'(resp_wb && (owed_raw != 2'd0));
    drop_cnt_d = drop_cnt_q - DW'(drop_hit) + (kill_wb_i ? DW'(owed_kill) : '0);
  end

  // Live beat replaces the stored one it is about to become.
  always_comb begin
    al_rdata0 = (st == WAIT0) ? resp_rdata_i : rdata0_q;
    al_rdata1 = (st == WAIT1) ? resp_rdata_i : rdata1_q;
    unique case (st)
      WAIT0:   err_cur = resp_err_i;
      WAIT1:   err_cur = err_q | resp_err_i;
      default: err_cur = err_q;
    endcase
  end

  cv32e40x_lsu_rdata_align u_align (
    .rdata0_i   (al_rdata0),
    .rdata1_i   (al_rdata1),
    .split_i    (split_i),
    .size_i     (size_i),
    .sext_i     (sext_i),
    .addr_lsb_i (addr_lsb_i),
    .rdata_o    (aligned)
  );

  // Drive WB-facing outputs; data and error are only meaningful with ready.
  always_comb begin
    lsu_ready_wb_o = ready;
    lsu_err_o      = data_req_wb_i && ready && err_cur;
    lsu_rdata_o    = (data_req_wb_i && ready && !we_i) ? aligned : '0;
    busy_o         = (st == WAIT0) || (st == WAIT1) || (drop_cnt_q != '0);
  end

  // Beat-tracking FSM with data/error capture and the drop counter; kill beats retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      if (kill_wb_i || retire) begin
        state_q <= IDLE;
        beat_q  <= '0;
        err_q   <= 1'b0;
        done_q  <= 1'b0;
      end else if (resp_wb) begin
        unique case (st)
          WAIT0: begin
            rdata0_q <= resp_rdata_i;
            err_q    <= resp_err_i;
            beat_q   <= 2'd1;
            if (split_i) begin
              state_q <= WAIT1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          WAIT1: begin
            rdata1_q <= resp_rdata_i;
            err_q    <= err_q | resp_err_i;
            beat_q   <= 2'd2;
            state_q  <= DONE;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end else if (st == WAIT0) begin
        state_q <= WAIT0;
      end
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_i |-> (st != IDLE || drop_cnt_q != '0));

  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= MAX_CNT);

  a_done_flag: assert property (@(posedge clk) disable iff (!rst_n)
    done_q == (state_q == DONE));

  a_beat_wait1: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == WAIT1) |-> (beat_q == 2'd1));

endmodule
